imem_loader: RTL



---
 rtl/imem_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a length/words/checksum frame and drives the
// instruction memory write port, holding the core in reset until a good load lands.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [15:0]       imem_wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            r_state, w_next;
  logic [15:0]       r_len;
  logic [7:0]        r_hi, r_csum;
  logic              r_ready, r_wr_en, r_hold, r_done, r_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic [ADDR_W:0]   r_words;
  logic              w_xfer, w_start, w_ready_nx;
  logic [ADDR_W:0]   w_words_inc;
  logic [15:0]       w_len_new;

  assign w_xfer      = byte_valid & r_ready;
  assign w_start     = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_words_inc = r_words + 1'b1;
  assign w_len_new   = {r_len[15:8], byte_data};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN_HI;
      S_LEN_HI:  if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO:
        if (w_xfer) begin
          if ({1'b0, w_len_new} > DEPTH_L) w_next = S_ERR;
          else if (w_len_new == 16'd0)     w_next = S_CHECK;
          else                             w_next = S_DATA_HI;
        end
      S_DATA_HI: if (w_xfer) w_next = S_DATA_LO;
      S_DATA_LO:
        if (w_xfer) w_next = (16'(w_words_inc) == r_len) ? S_CHECK : S_DATA_HI;
      S_CHECK:
        if (w_xfer) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
      default:   w_next = S_IDLE;
    endcase
  end

  // byte_ready is registered: it reflects the state the FSM is about to enter
  assign w_ready_nx = (w_next == S_LEN_HI) | (w_next == S_LEN_LO) | (w_next == S_DATA_HI) |
                      (w_next == S_DATA_LO) | (w_next == S_CHECK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_hold    <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_words   <= '0;
      r_csum    <= '0;
      r_len     <= '0;
      r_hi      <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_ready_nx;
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_words <= '0;
        r_csum  <= '0;
        r_hold  <= 1'b1;
      end
      // checksum byte itself is excluded from the running XOR
      if (w_xfer && r_state != S_CHECK) r_csum <= r_csum ^ byte_data;
      if (w_xfer) begin
        case (r_state)
          S_LEN_HI:  r_len[15:8] <= byte_data;
          S_LEN_LO:  r_len[7:0]  <= byte_data;
          S_DATA_HI: r_hi        <= byte_data;
          S_DATA_LO: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_words[ADDR_W-1:0];
            r_wr_data <= {r_hi, byte_data};
            r_words   <= w_words_inc;
          end
          default: ;
        endcase
      end
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_done <= 1'b1;
        r_hold <= 1'b0;
      end
      if (w_next == S_ERR && r_state != S_ERR) r_err <= 1'b1;
    end
  end

  assign byte_ready   = r_ready;
  assign imem_wr_en   = r_wr_en;
  assign imem_wr_addr = r_wr_addr;
  assign imem_wr_data = r_wr_data;
  assign core_hold    = r_hold;
  assign load_done    = r_done;
  assign load_err     = r_err;
  assign words_loaded = r_words;

endmodule
